// File: rtl/mdr_ctrl.sv
// Memory data register with bus load/drive and its own data-memory req/ready handshake.
// Handles byte/half/word loads with sign/zero extension and reports busy/done/err.
//
// state | meaning
// IDLE  | waiting for bus write or memory command
// REQ   | mem_req asserted, waiting for mem_ready or timeout
// DONE  | one-cycle completion pulse
module mdr_ctrl #(
    parameter int DATA_W  = 24,
    parameter int TIMEOUT = 15,
    parameter int TO_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write,
    input  logic              read_bus,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] Bus_out,
    output logic [DATA_W-1:0] DMEM,
    input  logic              mem_rd_cmd,
    input  logic              mem_wr_cmd,
    input  logic [1:0]        size,
    input  logic              sext,
    output logic              mem_req,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] mdr, mdr_nxt;
    logic [TO_W-1:0]   cnt, cnt_nxt;
    logic              err_q, err_nxt;
    logic              we_q, we_nxt;
    logic [1:0]        size_q, size_nxt;
    logic              sext_q, sext_nxt;
    logic [DATA_W-1:0] load_val;
    logic [TO_W-1:0]   cnt_inc;

    assign cnt_inc = cnt + 1'b1;

    // Narrow loads take the low byte/half; size is the value latched with the command.
    always_comb begin
        load_val = mem_rdata;
        case (size_q)
            2'b00: load_val = {{(DATA_W-8){sext_q & mem_rdata[7]}}, mem_rdata[7:0]};
            2'b01: load_val = {{(DATA_W-16){sext_q & mem_rdata[15]}}, mem_rdata[15:0]};
            default: load_val = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mdr    <= '0;
            cnt    <= '0;
            err_q  <= 1'b0;
            we_q   <= 1'b0;
            size_q <= 2'b00;
            sext_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            mdr    <= mdr_nxt;
            cnt    <= cnt_nxt;
            err_q  <= err_nxt;
            we_q   <= we_nxt;
            size_q <= size_nxt;
            sext_q <= sext_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mdr_nxt   = mdr;
        cnt_nxt   = cnt;
        err_nxt   = err_q;
        we_nxt    = we_q;
        size_nxt  = size_q;
        sext_nxt  = sext_q;
        case (state)
            IDLE: begin
                if (write) begin
                    mdr_nxt = data_in;
                end else if (mem_wr_cmd) begin
                    state_nxt = REQ;
                    we_nxt    = 1'b1;
                    err_nxt   = 1'b0;
                    cnt_nxt   = '0;
                end else if (mem_rd_cmd) begin
                    state_nxt = REQ;
                    we_nxt    = 1'b0;
                    size_nxt  = size;
                    sext_nxt  = sext;
                    err_nxt   = 1'b0;
                    cnt_nxt   = '0;
                end
            end
            REQ: begin
                if (mem_ready) begin
                    state_nxt = DONE;
                    if (!we_q) mdr_nxt = load_val;
                end else begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == TO_W'(TIMEOUT)) begin
                        state_nxt = IDLE;
                        err_nxt   = 1'b1;
                    end
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_req = (state == REQ);
    assign mem_we  = (state == REQ) && we_q;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign err     = err_q;
    assign DMEM    = mdr;
    assign Bus_out = read_bus ? mdr : '0;

endmodule

// File: tb/tb_mdr_ctrl.sv
// Directed bench for mdr_ctrl: expected load results are queued at command issue
// and popped/compared when the done pulse appears.
module tb_mdr_ctrl;
    localparam int DATA_W  = 24;
    localparam int TIMEOUT = 15;
    localparam int TO_W    = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              write = 1'b0;
    logic              read_bus = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic [DATA_W-1:0] Bus_out;
    logic [DATA_W-1:0] DMEM;
    logic              mem_rd_cmd = 1'b0;
    logic              mem_wr_cmd = 1'b0;
    logic [1:0]        size = 2'b00;
    logic              sext = 1'b0;
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_ready = 1'b0;
    logic              busy;
    logic              done;
    logic              err;

    int nchecks = 0;
    int nerr = 0;
    logic [DATA_W-1:0] exp_q[$];

    mdr_ctrl #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
        .clk(clk), .rst_n(rst_n), .write(write), .read_bus(read_bus),
        .data_in(data_in), .Bus_out(Bus_out), .DMEM(DMEM),
        .mem_rd_cmd(mem_rd_cmd), .mem_wr_cmd(mem_wr_cmd), .size(size), .sext(sext),
        .mem_req(mem_req), .mem_we(mem_we), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nchecks++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Load with k mem_ready-low edges in REQ before the acknowledging edge.
    task automatic do_load(input logic [1:0] sz, input logic sx, input logic [DATA_W-1:0] rdata,
                           input int k, input logic [DATA_W-1:0] expv, input string tag);
        int busy_cnt;
        int req_cnt;
        logic [DATA_W-1:0] e;
        mem_rd_cmd = 1'b1;
        size = sz;
        sext = sx;
        exp_q.push_back(expv);
        tick;
        mem_rd_cmd = 1'b0;
        size = ~sz;
        sext = ~sx;
        chk({tag, "_req"}, {31'd0, mem_req}, 32'd1);
        chk({tag, "_we"}, {31'd0, mem_we}, 32'd0);
        busy_cnt = 1;
        req_cnt = 1;
        for (int i = 0; i < k; i++) begin
            tick;
            if (busy) busy_cnt++;
            if (mem_req) req_cnt++;
        end
        mem_ready = 1'b1;
        mem_rdata = rdata;
        tick;
        mem_ready = 1'b0;
        mem_rdata = '0;
        if (busy) busy_cnt++;
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_req_cycles"}, req_cnt, k + 1);
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_data"}, {8'd0, DMEM}, {8'd0, e});
        end
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
        tick;
        chk({tag, "_idle"}, {30'd0, done, busy}, 32'd0);
        chk({tag, "_busy_cycles"}, busy_cnt, k + 2);
    endtask

    initial begin
        int n;
        logic saw_done;

        repeat (2) tick;
        chk("reset_dmem", {8'd0, DMEM}, 32'd0);
        chk("reset_ctrl", {28'd0, mem_req, mem_we, busy, err}, 32'd0);
        rst_n = 1'b1;
        tick;

        // Bus write, then bus read
        write = 1'b1;
        data_in = 24'd100;
        tick;
        write = 1'b0;
        chk("bus_out_off", {8'd0, Bus_out}, 32'd0);
        chk("dmem_100", {8'd0, DMEM}, 32'd100);
        read_bus = 1'b1;
        #1;
        chk("bus_out_on", {8'd0, Bus_out}, 32'd100);
        read_bus = 1'b0;
        tick;

        do_load(2'b10, 1'b1, 24'hABCDEF, 3, 24'hABCDEF, "word");
        do_load(2'b00, 1'b1, 24'h0080F0, 0, 24'hFFFFF0, "byte_s");
        do_load(2'b00, 1'b0, 24'h0080F0, 1, 24'h0000F0, "byte_z");
        do_load(2'b01, 1'b1, 24'h0080F0, 2, 24'hFF80F0, "half_s");
        do_load(2'b01, 1'b0, 24'hFF80F0, 0, 24'h0080F0, "half_z");
        // mem_ready on the TIMEOUT edge still completes
        do_load(2'b11, 1'b0, 24'h123456, TIMEOUT - 1, 24'h123456, "edge_to");

        // Store with write and read commands attempted during REQ
        write = 1'b1;
        data_in = 24'd80;
        tick;
        write = 1'b0;
        mem_wr_cmd = 1'b1;
        mem_rd_cmd = 1'b1;
        tick;
        mem_wr_cmd = 1'b0;
        mem_rd_cmd = 1'b0;
        chk("st_req", {30'd0, mem_req, mem_we}, 32'd3);
        write = 1'b1;
        data_in = 24'd5;
        tick;
        write = 1'b0;
        chk("st_write_ignored", {8'd0, DMEM}, 32'd80);
        chk("st_hold", {30'd0, mem_req, mem_we}, 32'd3);
        mem_ready = 1'b1;
        mem_rdata = 24'hFFFFFF;
        tick;
        mem_ready = 1'b0;
        chk("st_done", {31'd0, done}, 32'd1);
        chk("st_mdr", {8'd0, DMEM}, 32'd80);
        tick;
        chk("st_idle", {31'd0, busy}, 32'd0);

        // Timeout
        mem_rd_cmd = 1'b1;
        size = 2'b10;
        tick;
        mem_rd_cmd = 1'b0;
        n = 0;
        saw_done = 1'b0;
        while (mem_req && n < 40) begin
            n++;
            tick;
            if (done) saw_done = 1'b1;
        end
        chk("to_cycles", n, TIMEOUT);
        chk("to_err", {31'd0, err}, 32'd1);
        chk("to_no_done", {31'd0, saw_done}, 32'd0);
        chk("to_busy", {31'd0, busy}, 32'd0);
        chk("to_mdr", {8'd0, DMEM}, 32'd80);
        mem_wr_cmd = 1'b1;
        tick;
        mem_wr_cmd = 1'b0;
        chk("to_err_clr", {31'd0, err}, 32'd0);
        mem_ready = 1'b1;
        tick;
        mem_ready = 1'b0;
        chk("to_st_done", {31'd0, done}, 32'd1);
        tick;

        // write beats mem_rd_cmd in IDLE
        write = 1'b1;
        mem_rd_cmd = 1'b1;
        data_in = 24'h0A0B0C;
        tick;
        write = 1'b0;
        mem_rd_cmd = 1'b0;
        chk("conf_mdr", {8'd0, DMEM}, 32'h0A0B0C);
        chk("conf_noreq", {30'd0, mem_req, busy}, 32'd0);
        tick;

        // Async reset mid-REQ
        mem_rd_cmd = 1'b1;
        size = 2'b10;
        tick;
        mem_rd_cmd = 1'b0;
        tick;
        chk("rst_pre_req", {31'd0, mem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_req", {29'd0, mem_req, busy, done}, 32'd0);
        chk("rst_mdr", {8'd0, DMEM}, 32'd0);
        #1;
        rst_n = 1'b1;
        tick;
        do_load(2'b00, 1'b0, 24'h00007F, 1, 24'h00007F, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule

// File: doc/mdr_ctrl.md
Name: mdr_ctrl

Overview:
Parametrised memory data register for the datapath. It holds one DATA_W-bit word and loads it either from the internal bus (write) or from data memory. It drives the word onto the bus (read_bus) or out to data memory. Unlike a plain register, it owns the data-memory handshake (req/ready FSM with timeout), supports byte/half/word loads with sign or zero extension, and reports busy/done/err to the control unit.

Parameters:
DATA_W, 24, register and bus width; must be a multiple of 8 and at least 16
TIMEOUT, 15, max cycles waiting on mem_ready before abort; range 1..255
TO_W, 8, timeout counter width; must hold TIMEOUT

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
write  input  1  load data_in into MDR (bus -> MDR)
read_bus  input  1  drive MDR contents onto Bus_out
data_in  input  DATA_W  word from internal bus
Bus_out  output  DATA_W  MDR contents when read_bus=1, else 0
DMEM  output  DATA_W  MDR contents, always driven to data memory write port
mem_rd_cmd  input  1  start memory load into MDR
mem_wr_cmd  input  1  start memory store of MDR
size  input  2  load size: 00 byte, 01 half, 10/11 word; sampled with mem_rd_cmd
sext  input  1  1 = sign-extend narrow load, 0 = zero-extend; sampled with mem_rd_cmd
mem_req  output  1  request to data memory, held until mem_ready or timeout
mem_we  output  1  1 = store, 0 = load; valid while mem_req=1
mem_rdata  input  DATA_W  read data from memory, valid when mem_ready=1
mem_ready  input  1  memory acknowledge
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse on successful completion
err  output  1  sticky timeout flag

Behaviour:
- Reset (rst_n low, async): MDR=0, state=IDLE, counter=0, mem_req=0, mem_we=0, done=0, err=0; Bus_out=0, DMEM=0.
- Bus_out is combinational: read_bus ? MDR : 0. DMEM is always MDR. Neither depends on state.
- States: IDLE, REQ, DONE.
- IDLE, priority highest first:
  - write=1: MDR<=data_in next edge; any mem command in the same cycle is dropped.
  - mem_wr_cmd=1: go to REQ with mem_we=1.
  - mem_rd_cmd=1: go to REQ with mem_we=0, and latch size and sext. If mem_wr_cmd is also high, the store wins and the read is dropped.
  - Accepting any mem command clears err and the counter.
- REQ:
  - mem_req=1, mem_we per the latched command.
  - On an edge with mem_ready=1: go to DONE. For a load, MDR<=extended mem_rdata on that same edge. For a store, MDR is unchanged.
  - On an edge with mem_ready=0: counter increments. When the counter reaches TIMEOUT, go to IDLE, set err=1, leave MDR unchanged, and assert no done.
  - mem_ready at the TIMEOUT edge counts as success.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Minimum latency: command at edge N; mem_req high N..N+1; with mem_ready at edge N+1, done is high during cycle N+1..N+2; a new command is accepted at edge N+3.
- Ignored inputs: write, mem_rd_cmd and mem_wr_cmd are ignored while busy=1. mem_ready is ignored outside REQ.
- Extension rules:
  - Byte uses mem_rdata[7:0]; half uses [15:0].
  - Upper bits are 0 when sext=0, or copies of bit 7/15 when sext=1.
  - Word copies all DATA_W bits; sext is ignored.
- Async reset in REQ or DONE aborts the transfer: mem_req drops immediately and MDR clears.

Test Plan:
- Reset then write=1, data_in=24'd100, read_bus=0 -> Bus_out=0, DMEM=100 after the edge; then read_bus=1, write=0 -> Bus_out=100.
- Word load: mem_rd_cmd, size=10, mem_ready asserted 3 cycles after mem_req with mem_rdata=24'hABCDEF -> MDR=ABCDEF, done one cycle, busy for 5 cycles total, err=0.
- Narrow loads with mem_rdata=24'h00_80_F0:
  - byte, sext=1 -> FFFFF0
  - byte, sext=0 -> 0000F0
  - half, sext=1 -> FF80F0
- Store: write data_in=24'd80, then mem_wr_cmd -> mem_req=1 with mem_we=1 and DMEM=80 until mem_ready; done pulses; MDR stays 80.
- Timeout: TIMEOUT=15, mem_rd_cmd, never assert mem_ready -> mem_req drops after 15 cycles, err=1, no done, MDR unchanged; the next mem_wr_cmd clears err.
- Conflicts and reset: write+mem_rd_cmd in IDLE -> MDR<=data_in, no mem_req; write during REQ -> ignored; rst_n low mid-REQ -> mem_req=0 and MDR=0 immediately.
